// File: rtl/pcie_trn_tx_arbiter.sv
// Two-source round-robin arbiter for the Virtex-6 PCIe TRN transmit port.
// Grants at packet boundaries, gated on link-up and buffer availability; also hands the slot to config TLPs.
module pcie_trn_tx_arbiter #(
  parameter int unsigned BUF_MIN = 1
) (
  input  logic        trn_clk,
  input  logic        trn_reset_n,
  input  logic        trn_lnk_up_n,
  input  logic [5:0]  trn_tbuf_av,
  input  logic        trn_tdst_rdy_n,
  input  logic        trn_tcfg_req_n,
  output logic        trn_tcfg_gnt_n,
  output logic [63:0] trn_td,
  output logic        trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  output logic        trn_terrfwd_n,
  output logic        trn_tstr_n,
  input  logic [63:0] r0_td,
  input  logic        r0_trem_n,
  input  logic        r0_tsof_n,
  input  logic        r0_teof_n,
  input  logic        r0_tsrc_rdy_n,
  output logic        r0_tdst_rdy_n,
  input  logic [63:0] r1_td,
  input  logic        r1_trem_n,
  input  logic        r1_tsof_n,
  input  logic        r1_teof_n,
  input  logic        r1_tsrc_rdy_n,
  output logic        r1_tdst_rdy_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t r_state;
  logic   r_own;
  logic   r_last;
  logic   r_cfg_gnt_n;

  logic w_req0;
  logic w_req1;
  logic w_buf_ok;
  logic w_next;
  logic w_busy;
  logic w_xfer;

  assign w_req0   = ~r0_tsrc_rdy_n & ~r0_tsof_n;
  assign w_req1   = ~r1_tsrc_rdy_n & ~r1_tsof_n;
  assign w_buf_ok = (32'(trn_tbuf_av) >= BUF_MIN);
  // On a tie the requester that did not go last wins.
  assign w_next   = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_busy   = (r_state == S_BUSY);
  assign w_xfer   = w_busy & ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;

  assign trn_tcfg_gnt_n = r_cfg_gnt_n;
  assign trn_tsrc_dsc_n = 1'b1;
  assign trn_terrfwd_n  = 1'b1;
  assign trn_tstr_n     = 1'b1;

  always_comb begin
    trn_td         = '0;
    trn_trem_n     = 1'b1;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    r0_tdst_rdy_n  = 1'b1;
    r1_tdst_rdy_n  = 1'b1;
    if (w_busy) begin
      if (r_own) begin
        trn_td         = r1_td;
        trn_trem_n     = r1_trem_n;
        trn_tsof_n     = r1_tsof_n;
        trn_teof_n     = r1_teof_n;
        trn_tsrc_rdy_n = r1_tsrc_rdy_n;
      end else begin
        trn_td         = r0_td;
        trn_trem_n     = r0_trem_n;
        trn_tsof_n     = r0_tsof_n;
        trn_teof_n     = r0_teof_n;
        trn_tsrc_rdy_n = r0_tsrc_rdy_n;
      end
      // Link loss withholds ready so the abandoned packet loses no extra beats.
      if (!trn_lnk_up_n) begin
        if (r_own) r1_tdst_rdy_n = trn_tdst_rdy_n;
        else       r0_tdst_rdy_n = trn_tdst_rdy_n;
      end
    end
  end

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_state     <= S_IDLE;
      r_own       <= 1'b0;
      r_last      <= 1'b1;
      r_cfg_gnt_n <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!trn_lnk_up_n) begin
            if (!trn_tcfg_req_n) begin
              r_state     <= S_CFG;
              r_cfg_gnt_n <= 1'b0;
            end else if ((w_req0 | w_req1) && w_buf_ok) begin
              r_state <= S_BUSY;
              r_own   <= w_next;
              r_last  <= w_next;
            end
          end
        end
        S_CFG: begin
          if (trn_lnk_up_n || trn_tcfg_req_n) begin
            r_state     <= S_IDLE;
            r_cfg_gnt_n <= 1'b1;
          end
        end
        S_BUSY: begin
          if (trn_lnk_up_n || (w_xfer && !trn_teof_n)) r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cfg_gnt_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_trn_tx_arbiter.sv
// Directed bench for pcie_trn_tx_arbiter: two packet-source models, a beat logger and per-scenario checks.
module tb_pcie_trn_tx_arbiter;

  logic        trn_clk;
  logic        trn_reset_n;
  logic        trn_lnk_up_n;
  logic [5:0]  trn_tbuf_av;
  logic        trn_tdst_rdy_n;
  logic        trn_tcfg_req_n;
  logic        trn_tcfg_gnt_n;
  logic [63:0] trn_td;
  logic        trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic        trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n;
  logic [63:0] r0_td, r1_td;
  logic        r0_trem_n, r0_tsof_n, r0_teof_n, r0_tsrc_rdy_n, r0_tdst_rdy_n;
  logic        r1_trem_n, r1_tsof_n, r1_teof_n, r1_tsrc_rdy_n, r1_tdst_rdy_n;

  int n_checks;
  int n_pass;

  // Source models: s_req packets requested, s_done completed, s_beat current beat.
  int s_req[2];
  int s_done[2];
  int s_beat[2];
  int s_len[2];

  // Beat log of every transfer accepted by the core.
  logic [63:0] m_td[256];
  logic [2:0]  m_fl[256];
  int          m_cyc[256];
  int          m_n;
  int          cyc;

  pcie_trn_tx_arbiter #(.BUF_MIN(2)) dut (
    .trn_clk(trn_clk), .trn_reset_n(trn_reset_n), .trn_lnk_up_n(trn_lnk_up_n),
    .trn_tbuf_av(trn_tbuf_av), .trn_tdst_rdy_n(trn_tdst_rdy_n),
    .trn_tcfg_req_n(trn_tcfg_req_n), .trn_tcfg_gnt_n(trn_tcfg_gnt_n),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
    .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n(trn_tsrc_dsc_n), .trn_terrfwd_n(trn_terrfwd_n), .trn_tstr_n(trn_tstr_n),
    .r0_td(r0_td), .r0_trem_n(r0_trem_n), .r0_tsof_n(r0_tsof_n), .r0_teof_n(r0_teof_n),
    .r0_tsrc_rdy_n(r0_tsrc_rdy_n), .r0_tdst_rdy_n(r0_tdst_rdy_n),
    .r1_td(r1_td), .r1_trem_n(r1_trem_n), .r1_tsof_n(r1_tsof_n), .r1_teof_n(r1_teof_n),
    .r1_tsrc_rdy_n(r1_tsrc_rdy_n), .r1_tdst_rdy_n(r1_tdst_rdy_n)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  assign r0_td         = {32'd0, s_done[0][15:0], s_beat[0][15:0]};
  assign r0_tsrc_rdy_n = ~(s_done[0] < s_req[0]);
  assign r0_tsof_n     = ~(s_beat[0] == 0);
  assign r0_teof_n     = ~(s_beat[0] == s_len[0] - 1);
  assign r0_trem_n     = s_beat[0][0];
  assign r1_td         = {32'd1, s_done[1][15:0], s_beat[1][15:0]};
  assign r1_tsrc_rdy_n = ~(s_done[1] < s_req[1]);
  assign r1_tsof_n     = ~(s_beat[1] == 0);
  assign r1_teof_n     = ~(s_beat[1] == s_len[1] - 1);
  assign r1_trem_n     = s_beat[1][0];

  // A requester restarts from SOF on reset or link loss.
  always @(posedge trn_clk) begin
    if (!trn_reset_n || trn_lnk_up_n) begin
      s_beat[0] <= 0;
      s_beat[1] <= 0;
    end else begin
      if (!r0_tsrc_rdy_n && !r0_tdst_rdy_n) begin
        if (s_beat[0] == s_len[0] - 1) begin
          s_beat[0] <= 0;
          s_done[0] <= s_done[0] + 1;
        end else s_beat[0] <= s_beat[0] + 1;
      end
      if (!r1_tsrc_rdy_n && !r1_tdst_rdy_n) begin
        if (s_beat[1] == s_len[1] - 1) begin
          s_beat[1] <= 0;
          s_done[1] <= s_done[1] + 1;
        end else s_beat[1] <= s_beat[1] + 1;
      end
    end
  end

  always @(posedge trn_clk) begin
    cyc <= cyc + 1;
    if (trn_reset_n && !trn_lnk_up_n && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
      m_td[m_n[7:0]]  <= trn_td;
      m_fl[m_n[7:0]]  <= {trn_tsof_n, trn_teof_n, trn_trem_n};
      m_cyc[m_n[7:0]] <= cyc;
      m_n             <= m_n + 1;
    end
  end

  function automatic logic [66:0] exp_beat(input int n, input int seq, input int beat, input int len);
    logic [15:0] s;
    logic [15:0] b;
    s = 16'(seq);
    b = 16'(beat);
    return {32'(n), s, b, beat != 0, beat != len - 1, b[0]};
  endfunction

  task automatic tick;
    @(posedge trn_clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < budget) begin
      tick();
      ok = (s_done[0] >= s_req[0]) && (s_done[1] >= s_req[1]);
      i++;
    end
  endtask

  task automatic test_reset;
    @(negedge trn_clk);
    n_checks++;
    if ({trn_tcfg_gnt_n, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, r0_tdst_rdy_n, r1_tdst_rdy_n} !== 7'h7f)
      $display("FAIL reset_ctl: got %b expected 1111111",
               {trn_tcfg_gnt_n, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, r0_tdst_rdy_n, r1_tdst_rdy_n});
    else n_pass++;
    n_checks++;
    if ({trn_td, trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n} !== {64'd0, 3'b111})
      $display("FAIL reset_td: got %h/%b expected 0/111", trn_td, {trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n});
    else n_pass++;
    tick();
    trn_reset_n = 1'b1;
  endtask

  task automatic test_tie;
    int rd, n0, b0, b1, k, own, seq, idx;
    bit ok;
    tick();
    rd = m_n; n0 = cyc; b0 = s_done[0]; b1 = s_done[1];
    s_len[0] = 2; s_len[1] = 2;
    s_req[0] = s_req[0] + 3;
    s_req[1] = s_req[1] + 3;
    wait_idle(60, ok);
    n_checks++;
    if (!ok) $display("FAIL tie_timeout: got done=%0d/%0d expected %0d/%0d", s_done[0], s_done[1], s_req[0], s_req[1]);
    else n_pass++;
    n_checks++;
    if (m_n - rd !== 12) $display("FAIL tie_count: got %0d expected 12", m_n - rd);
    else n_pass++;
    for (k = 0; k < 6; k++) begin
      own = k % 2;
      seq = (own == 1 ? b1 : b0) + k / 2;
      for (int b = 0; b < 2; b++) begin
        idx = rd + 2 * k + b;
        n_checks++;
        if ({m_td[idx], m_fl[idx]} !== exp_beat(own, seq, b, 2) || m_cyc[idx] !== n0 + 1 + 3 * k + b)
          $display("FAIL tie_beat%0d: got %h/%b@%0d expected %h@%0d", idx - rd, m_td[idx], m_fl[idx],
                   m_cyc[idx], exp_beat(own, seq, b, 2), n0 + 1 + 3 * k + b);
        else n_pass++;
      end
    end
  endtask

  task automatic test_single;
    int rd, n0, seq, j;
    bit r1_bad;
    tick();
    rd = m_n; n0 = cyc; seq = s_done[0]; r1_bad = 1'b0;
    s_len[0] = 4;
    s_req[0] = s_req[0] + 1;
    tick();
    @(negedge trn_clk);
    n_checks++;
    if ({trn_tsof_n, trn_tsrc_rdy_n} !== 2'b00) $display("FAIL single_sof: got %b expected 00", {trn_tsof_n, trn_tsrc_rdy_n});
    else n_pass++;
    j = 0;
    while (s_done[0] < s_req[0] && j < 20) begin
      if (r1_tdst_rdy_n !== 1'b1) r1_bad = 1'b1;
      tick();
      @(negedge trn_clk);
      j++;
    end
    n_checks++;
    if (r1_bad || j >= 20) $display("FAIL single_r1rdy: got bad=%0d cycles=%0d expected bad=0 cycles<20", r1_bad, j);
    else n_pass++;
    n_checks++;
    if ({trn_tsrc_rdy_n, r0_tdst_rdy_n} !== 2'b11) $display("FAIL single_idle: got %b expected 11", {trn_tsrc_rdy_n, r0_tdst_rdy_n});
    else n_pass++;
    n_checks++;
    if (m_n - rd !== 4) $display("FAIL single_count: got %0d expected 4", m_n - rd);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({m_td[rd + i], m_fl[rd + i]} !== exp_beat(0, seq, i, 4) || m_cyc[rd + i] !== n0 + 1 + i)
        $display("FAIL single_beat%0d: got %h/%b@%0d expected %h@%0d", i, m_td[rd + i], m_fl[rd + i],
                 m_cyc[rd + i], exp_beat(0, seq, i, 4), n0 + 1 + i);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    int rd, n0, seq, ec;
    bit ok;
    tick();
    rd = m_n; n0 = cyc; seq = s_done[0];
    s_len[0] = 6;
    s_req[0] = s_req[0] + 1;
    tick(); tick(); tick();
    trn_tdst_rdy_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge trn_clk);
      n_checks++;
      if ({r0_tdst_rdy_n, r1_tdst_rdy_n} !== 2'b11) $display("FAIL bp_stall%0d: got %b expected 11", i, {r0_tdst_rdy_n, r1_tdst_rdy_n});
      else n_pass++;
      tick();
    end
    trn_tdst_rdy_n = 1'b0;
    @(negedge trn_clk);
    n_checks++;
    if ({r0_tdst_rdy_n, r1_tdst_rdy_n} !== 2'b01) $display("FAIL bp_resume: got %b expected 01", {r0_tdst_rdy_n, r1_tdst_rdy_n});
    else n_pass++;
    wait_idle(20, ok);
    n_checks++;
    if (!ok || m_n - rd !== 6) $display("FAIL bp_count: got ok=%0d beats=%0d expected 1/6", ok, m_n - rd);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      ec = n0 + 1 + i + (i >= 2 ? 3 : 0);
      n_checks++;
      if ({m_td[rd + i], m_fl[rd + i]} !== exp_beat(0, seq, i, 6) || m_cyc[rd + i] !== ec)
        $display("FAIL bp_beat%0d: got %h/%b@%0d expected %h@%0d", i, m_td[rd + i], m_fl[rd + i],
                 m_cyc[rd + i], exp_beat(0, seq, i, 6), ec);
      else n_pass++;
    end
  endtask

  task automatic test_cfg;
    int rd, n0, seq0, seq1;
    logic [1:0] exp;
    tick();
    rd = m_n; n0 = cyc; seq0 = s_done[0]; seq1 = s_done[1];
    s_len[1] = 5; s_len[0] = 1;
    s_req[1] = s_req[1] + 1;
    for (int j = 1; j <= 13; j++) begin
      tick();
      if (j == 2) begin
        trn_tcfg_req_n = 1'b0;
        s_req[0] = s_req[0] + 1;
      end
      if (j == 9) trn_tcfg_req_n = 1'b1;
      @(negedge trn_clk);
      exp = {(j >= 7 && j <= 9) ? 1'b0 : 1'b1, (j <= 5 || j == 11) ? 1'b0 : 1'b1};
      n_checks++;
      if ({trn_tcfg_gnt_n, trn_tsrc_rdy_n} !== exp)
        $display("FAIL cfg_cyc%0d: got gnt/src=%b expected %b", j, {trn_tcfg_gnt_n, trn_tsrc_rdy_n}, exp);
      else n_pass++;
    end
    n_checks++;
    if (m_n - rd !== 6) $display("FAIL cfg_count: got %0d expected 6", m_n - rd);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({m_td[rd + i], m_fl[rd + i]} !== exp_beat(1, seq1, i, 5) || m_cyc[rd + i] !== n0 + 1 + i)
        $display("FAIL cfg_r1beat%0d: got %h/%b@%0d expected %h@%0d", i, m_td[rd + i], m_fl[rd + i],
                 m_cyc[rd + i], exp_beat(1, seq1, i, 5), n0 + 1 + i);
      else n_pass++;
    end
    n_checks++;
    if ({m_td[rd + 5], m_fl[rd + 5]} !== exp_beat(0, seq0, 0, 1) || m_cyc[rd + 5] !== n0 + 11)
      $display("FAIL cfg_r0beat: got %h/%b@%0d expected %h@%0d", m_td[rd + 5], m_fl[rd + 5],
               m_cyc[rd + 5], exp_beat(0, seq0, 0, 1), n0 + 11);
    else n_pass++;
  endtask

  task automatic test_bufgate;
    int rd, n0, seq;
    bit ok;
    logic [1:0] exp;
    tick();
    rd = m_n; n0 = cyc; seq = s_done[0];
    trn_tbuf_av = 6'd1;
    s_len[0] = 2;
    s_req[0] = s_req[0] + 1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 4) trn_tbuf_av = 6'd2;
      @(negedge trn_clk);
      exp = (j == 5) ? 2'b00 : 2'b11;
      n_checks++;
      if ({trn_tsrc_rdy_n, trn_tsof_n} !== exp) $display("FAIL buf_cyc%0d: got %b expected %b", j, {trn_tsrc_rdy_n, trn_tsof_n}, exp);
      else n_pass++;
    end
    wait_idle(20, ok);
    trn_tbuf_av = 6'd8;
    n_checks++;
    if (!ok || m_n - rd !== 2 || m_cyc[rd] !== n0 + 5 || {m_td[rd + 1], m_fl[rd + 1]} !== exp_beat(0, seq, 1, 2))
      $display("FAIL buf_pkt: got ok=%0d beats=%0d first@%0d last=%h expected 1/2/%0d/%h", ok, m_n - rd,
               m_cyc[rd], m_td[rd + 1], n0 + 5, exp_beat(0, seq, 1, 2));
    else n_pass++;
  endtask

  task automatic test_linkloss;
    int rd, n0, seq, b, ec;
    bit ok;
    tick();
    rd = m_n; n0 = cyc; seq = s_done[1];
    s_len[1] = 4;
    s_req[1] = s_req[1] + 1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 3) trn_lnk_up_n = 1'b1;
      if (j == 5) trn_lnk_up_n = 1'b0;
      @(negedge trn_clk);
      if (j >= 4) begin
        n_checks++;
        if ({r0_tdst_rdy_n, r1_tdst_rdy_n, trn_tsrc_rdy_n} !== 3'b111)
          $display("FAIL link_rdy%0d: got %b expected 111", j, {r0_tdst_rdy_n, r1_tdst_rdy_n, trn_tsrc_rdy_n});
        else n_pass++;
      end
    end
    wait_idle(20, ok);
    n_checks++;
    if (!ok || m_n - rd !== 6) $display("FAIL link_count: got ok=%0d beats=%0d expected 1/6", ok, m_n - rd);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      b  = (i < 2) ? i : i - 2;
      ec = (i < 2) ? n0 + 1 + i : n0 + 4 + i;
      n_checks++;
      if ({m_td[rd + i], m_fl[rd + i]} !== exp_beat(1, seq, b, 4) || m_cyc[rd + i] !== ec)
        $display("FAIL link_beat%0d: got %h/%b@%0d expected %h@%0d", i, m_td[rd + i], m_fl[rd + i],
                 m_cyc[rd + i], exp_beat(1, seq, b, 4), ec);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int rd;
    bit ok;
    tick();
    rd = m_n;
    s_len[0] = 4;
    s_req[0] = s_req[0] + 1;
    tick(); tick();
    #2;
    n_checks++;
    if ({trn_tsrc_rdy_n, r0_tdst_rdy_n} !== 2'b00) $display("FAIL rstmid_busy: got %b expected 00", {trn_tsrc_rdy_n, r0_tdst_rdy_n});
    else n_pass++;
    trn_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({trn_tcfg_gnt_n, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, r0_tdst_rdy_n, r1_tdst_rdy_n} !== 7'h7f
        || trn_td !== 64'd0)
      $display("FAIL rstmid_out: got %b td=%h expected 1111111 td=0",
               {trn_tcfg_gnt_n, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, r0_tdst_rdy_n, r1_tdst_rdy_n}, trn_td);
    else n_pass++;
    tick(); tick();
    trn_reset_n = 1'b1;
    wait_idle(20, ok);
    n_checks++;
    if (!ok || m_n - rd !== 5) $display("FAIL rstmid_resend: got ok=%0d beats=%0d expected 1/5", ok, m_n - rd);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    trn_reset_n    = 1'b0;
    trn_lnk_up_n   = 1'b0;
    trn_tbuf_av    = 6'd8;
    trn_tdst_rdy_n = 1'b0;
    trn_tcfg_req_n = 1'b1;
    s_len[0] = 1; s_len[1] = 1;
    s_req[0] = 0; s_req[1] = 0;
    tick();
    test_reset();
    test_tie();
    test_single();
    test_backpressure();
    test_cfg();
    test_bufgate();
    test_linkloss();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
